// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared mode and state encodings for the SAP-1 run controller
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_FREE = 2'b00,
      MODE_STEP = 2'b01,
      MODE_RUNN = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RESET = 2'b01,
      ST_RUN   = 2'b10,
      ST_STEP  = 2'b11
   } state_t;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - programmable rate divider, one tick every value+1 enabled clocks
module tick_divider #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_value,
   input  logic             i_en,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_div <= i_value;
         r_cnt <= i_value;
      end else if (i_en) begin
         if (r_cnt == '0) r_cnt <= r_div;
         else             r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - run/step/run-N controller generating cpu_ce and cpu_reset for SAP-1
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int DIV_W      = 8,
   parameter int RST_CYCLES = 1,
   parameter int MAX_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             step,
   input  logic             stop,
   input  logic [CNT_W-1:0] count_n,
   input  logic [DIV_W-1:0] div,
   input  logic             cpu_halted,
   output logic             cpu_ce,
   output logic             cpu_reset,
   output logic             busy,
   output logic             done,
   output logic             halted_seen,
   output logic             timeout,
   output logic [CNT_W-1:0] cycles
);

   localparam int               RC_W     = $clog2(RST_CYCLES + 1);
   localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);

   state_t           r_state;
   mode_t            r_mode;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_cycles;
   logic [RC_W-1:0]  r_rst_cnt;
   logic             r_pending;
   logic             r_done;
   logic             r_halted_seen;
   logic             r_timeout;

   logic             w_tick;
   logic             w_load;
   logic             w_issue;
   logic             w_budget_end;
   logic [CNT_W-1:0] w_cycles_inc;

   assign w_load       = start && (r_state == ST_IDLE);
   assign w_budget_end = (r_mode == MODE_RUNN) && (r_cycles == r_count);
   assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + 1'b1;

   tick_divider #(.DIV_W(DIV_W)) u_div (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_load  (w_load),
      .i_value (div),
      .i_en    (r_state != ST_IDLE),
      .o_tick  (w_tick)
   );

   // cpu_ce stays combinational so a same-clock stop or halt can veto the pulse
   always_comb begin
      w_issue = 1'b0;
      if (!stop && w_tick) begin
         case (r_state)
            ST_RESET: w_issue = 1'b1;
            ST_RUN:   w_issue = !cpu_halted && !w_budget_end;
            ST_STEP:  w_issue = !cpu_halted && r_pending;
            default:  w_issue = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_mode        <= MODE_FREE;
         r_count       <= '0;
         r_cycles      <= '0;
         r_rst_cnt     <= '0;
         r_pending     <= 1'b0;
         r_done        <= 1'b0;
         r_halted_seen <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mode        <= mode_t'(mode);
                  r_count       <= count_n;
                  r_cycles      <= '0;
                  r_halted_seen <= 1'b0;
                  r_timeout     <= 1'b0;
                  r_rst_cnt     <= '0;
                  r_pending     <= 1'b0;
                  r_state       <= ST_RESET;
               end
            end
            ST_RESET: begin
               if (stop) begin
                  r_state <= ST_IDLE;
               end else if (w_tick) begin
                  if (r_rst_cnt == RST_LAST)
                     r_state <= (r_mode == MODE_STEP) ? ST_STEP : ST_RUN;
                  else
                     r_rst_cnt <= r_rst_cnt + 1'b1;
               end
            end
            default: begin
               // a step arriving while one is already pending is dropped
               if (w_issue)
                  r_pending <= 1'b0;
               else if (step && (r_state == ST_STEP))
                  r_pending <= 1'b1;

               if (stop) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end else if (w_tick && cpu_halted) begin
                  r_halted_seen <= 1'b1;
                  r_state       <= ST_IDLE;
                  r_done        <= 1'b1;
               end else if (w_issue) begin
                  r_cycles <= w_cycles_inc;
                  if (w_cycles_inc == MAX_C) begin
                     r_timeout <= 1'b1;
                     r_state   <= ST_IDLE;
                     r_done    <= 1'b1;
                  end else if ((r_mode == MODE_RUNN) && (w_cycles_inc == r_count)) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end else if (w_budget_end) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign cpu_ce      = w_issue;
   assign cpu_reset   = w_issue && (r_state == ST_RESET);
   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign halted_seen = r_halted_seen;
   assign timeout     = r_timeout;
   assign cycles      = r_cycles;

endmodule
